// File: rtl/or_reduce_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined OR/NOR reduction tree.
package or_reduce_pkg;

    localparam int unsigned DEFAULT_FANIN = 4;

    // Integer power, used to size each tree level.
    function automatic int unsigned or_reduce_pow(input int unsigned base, input int unsigned exp);
        int unsigned acc;
        acc = 1;
        for (int unsigned i = 0; i < exp; i++) begin
            acc = acc * base;
        end
        return acc;
    endfunction

    // Ceiling log base fanin of width, never less than one level.
    function automatic int unsigned or_reduce_levels(input int unsigned width, input int unsigned fanin);
        int unsigned levels;
        int unsigned span;
        levels = 1;
        span   = fanin;
        while (span < width) begin
            span   = span * fanin;
            levels = levels + 1;
        end
        return levels;
    endfunction

    function automatic int unsigned or_reduce_pad_width(input int unsigned width, input int unsigned fanin);
        return or_reduce_pow(fanin, or_reduce_levels(width, fanin));
    endfunction

endpackage

// File: rtl/or_reduce_node.sv
// One FANIN-input OR node of the reduction tree (purely combinational).
module or_reduce_node
    import or_reduce_pkg::*;
#(
    parameter int unsigned FANIN = DEFAULT_FANIN
) (
    input  logic [FANIN-1:0] bits,
    output logic             any
);

    assign any = |bits;

endmodule

// File: rtl/or_reduce_pipe.sv
// Pipelined OR/NOR reduction with a global stall and valid/ready handshake.
// Optional sticky accumulator enabled by defining OR_REDUCE_STICKY_EN.
module or_reduce_pipe
    import or_reduce_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FANIN = DEFAULT_FANIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_invert,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result
`ifdef OR_REDUCE_STICKY_EN
    ,
    input  logic             sticky_clr,
    output logic             sticky
`endif
);

    localparam int unsigned LEVELS = or_reduce_levels(WIDTH, FANIN);
    localparam int unsigned PAD_W  = or_reduce_pad_width(WIDTH, FANIN);

    logic              stall;
    logic [PAD_W-1:0]  padded;
    logic [LEVELS-1:0] valid_q;
    logic [LEVELS-1:0] inv_src;

    // Whole pipe freezes only when the last stage holds an unaccepted result.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign padded   = PAD_W'(in_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (!stall) begin
            valid_q <= LEVELS'({valid_q, in_valid});
        end
    end

    assign out_valid = valid_q[LEVELS-1];

    // inv_src[k] is the invert flag travelling with the word entering level k.
    if (LEVELS == 1) begin : g_inv_single
        assign inv_src = in_invert;
    end else begin : g_inv_chain
        logic [LEVELS-2:0] inv_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                inv_q <= '0;
            end else if (!stall) begin
                inv_q <= inv_src[LEVELS-2:0];
            end
        end

        assign inv_src = {inv_q, in_invert};
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int unsigned OUT_W = or_reduce_pow(FANIN, LEVELS - 1 - k);

        logic [OUT_W*FANIN-1:0] src;
        logic [OUT_W-1:0]       red;
        logic [OUT_W-1:0]       q;

        if (k == 0) begin : g_src_in
            assign src = padded;
        end else begin : g_src_prev
            assign src = g_lvl[k-1].q;
        end

        for (genvar n = 0; n < OUT_W; n++) begin : g_node
            or_reduce_node #(
                .FANIN (FANIN)
            ) u_node (
                .bits (src[n*FANIN +: FANIN]),
                .any  (red[n])
            );
        end

        // Final level folds in the invert so the output comes straight from a flop.
        if (k == LEVELS - 1) begin : g_last
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (!stall) begin
                    q <= red ^ OUT_W'(inv_src[k]);
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (!stall) begin
                    q <= red;
                end
            end
        end
    end

    assign out_result = g_lvl[LEVELS-1].q;

`ifdef OR_REDUCE_STICKY_EN
    // A result accepted in the clearing cycle still lands in sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky <= 1'b0;
        end else begin
            sticky <= (sticky & ~sticky_clr) | (out_valid & out_ready & out_result);
        end
    end
`endif

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Scoreboard bench for or_reduce_pipe: WIDTH=32, WIDTH=1 and WIDTH=33 instances.
// Sticky checks are included when OR_REDUCE_STICKY_EN is defined.
module tb_or_reduce_pipe;

    typedef struct {
        logic res;
        int   cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  in_invert;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  out_result;
    logic [31:0] d_a;
    logic [0:0]  d_b;
    logic [32:0] d_c;
`ifdef OR_REDUCE_STICKY_EN
    logic [2:0]  sticky_clr;
    logic [2:0]  sticky;
`endif

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   lat[3] = '{3, 1, 3};
    exp_t q[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    or_reduce_pipe #(.WIDTH(32), .FANIN(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(d_a), .in_invert(in_invert[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_result(out_result[0])
`ifdef OR_REDUCE_STICKY_EN
        , .sticky_clr(sticky_clr[0]), .sticky(sticky[0])
`endif
    );

    or_reduce_pipe #(.WIDTH(1), .FANIN(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(d_b), .in_invert(in_invert[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_result(out_result[1])
`ifdef OR_REDUCE_STICKY_EN
        , .sticky_clr(sticky_clr[1]), .sticky(sticky[1])
`endif
    );

    or_reduce_pipe #(.WIDTH(33), .FANIN(4)) u_dut_c (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(d_c), .in_invert(in_invert[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_result(out_result[2])
`ifdef OR_REDUCE_STICKY_EN
        , .sticky_clr(sticky_clr[2]), .sticky(sticky[2])
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, req, cyc);
        end
    endtask

    // Pops one expectation per output transfer; runs for the whole simulation.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 3; i++) begin
                    if (out_valid[i] && out_ready[i]) begin
                        n_cmp++;
                        if (q[i].size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_out dut%0d: got result %0b with nothing pending (cycle %0d)",
                                     i, out_result[i], cyc);
                        end else begin
                            e = q[i].pop_front();
                            if (out_result[i] !== e.res || (e.cyc >= 0 && cyc != e.cyc)) begin
                                n_fail++;
                                $display("FAIL result dut%0d: got %0b at cycle %0d, required %0b at cycle %0d",
                                         i, out_result[i], cyc, e.res, e.cyc);
                            end
                        end
                    end
                end
            end
        end
    endtask

    // Presents a word to DUT i and holds it until accepted.
    task automatic offer(input int i, input logic [32:0] data, input logic inv, input logic res, input bit chk_lat);
        int   waited;
        exp_t e;
        waited = 0;
        @(posedge clk);
        #1;
        in_valid     = '0;
        in_valid[i]  = 1'b1;
        in_invert[i] = inv;
        case (i)
            0:       d_a = data[31:0];
            1:       d_b = data[0:0];
            default: d_c = data;
        endcase
        #1;
        while (!in_ready[i] && waited < 50) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (!in_ready[i]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL offer_timeout dut%0d: in_ready stayed 0, required 1 within 50 cycles", i);
        end else begin
            e.res = res;
            e.cyc = chk_lat ? cyc + lat[i] : -1;
            q[i].push_back(e);
        end
    endtask

    task automatic bubble();
        @(posedge clk);
        #1;
        in_valid = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bubble();
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0",
                     q[0].size() + q[1].size() + q[2].size());
            for (int i = 0; i < 3; i++) q[i].delete();
        end
    endtask

    // Holds rst for ncyc rising edges; pending expectations are discarded.
    task automatic do_reset(input int ncyc);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        for (int i = 0; i < 3; i++) q[i].delete();
        repeat (ncyc - 1) @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = '1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_invert = '0;
        out_ready = '0;
        d_a       = '0;
        d_b       = '0;
        d_c       = '0;
`ifdef OR_REDUCE_STICKY_EN
        sticky_clr = '0;
`endif
        fork
            monitor();
            begin
                #400000;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1);
            end
        join_none

        // Reset then idle
        do_reset(2);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_result", 32'(out_result), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h7);
`ifdef OR_REDUCE_STICKY_EN
        check("reset_sticky", 32'(sticky), 32'h0);
`endif

        // Directed OR / NOR
        offer(0, 33'h0_0000_0000, 1'b0, 1'b0, 1'b1);
        offer(0, 33'h0_8000_0000, 1'b0, 1'b1, 1'b1);
        offer(0, 33'h0_0000_0000, 1'b1, 1'b1, 1'b1);
        offer(0, 33'h0_0001_0000, 1'b1, 1'b0, 1'b1);
        drain();

        // Back-to-back single-bit stream, one bubble, then zero
        for (int i = 0; i < 8; i++) offer(0, 33'(1) << i, 1'b0, 1'b1, 1'b1);
        bubble();
        offer(0, 33'h0, 1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure: 4 stall cycles once the first result is presented
        fork
            begin
                offer(0, 33'h0_0000_0001, 1'b0, 1'b1, 1'b0);
                offer(0, 33'h0_0000_0000, 1'b0, 1'b0, 1'b0);
                offer(0, 33'h0_0000_0000, 1'b1, 1'b1, 1'b0);
                offer(0, 33'h0_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
                offer(0, 33'h0_0000_4000, 1'b0, 1'b1, 1'b0);
                bubble();
            end
            begin
                int n;
                n = 0;
                @(posedge clk);
                #1;
                while (!out_valid[0] && n < 20) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("stall_wait_out_valid", 32'(out_valid[0]), 32'h1);
                out_ready[0] = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    #1;
                    check("stall_in_ready", 32'(in_ready[0]), 32'h0);
                    check("stall_out_valid", 32'(out_valid[0]), 32'h1);
                    check("stall_out_result", 32'(out_result[0]), 32'h1);
                    @(posedge clk);
                    #1;
                end
                out_ready[0] = 1'b1;
            end
        join
        drain();

        // Reset mid-flight: three accepted words must never emerge
        offer(0, 33'h0_0000_0001, 1'b0, 1'b1, 1'b1);
        offer(0, 33'h0_0000_0002, 1'b0, 1'b1, 1'b1);
        offer(0, 33'h0_0000_0004, 1'b0, 1'b1, 1'b1);
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            check("post_reset_idle", 32'(out_valid[0]), 32'h0);
            @(posedge clk);
            #1;
        end
        offer(0, 33'h0_0000_0002, 1'b0, 1'b1, 1'b1);
        drain();

`ifdef OR_REDUCE_STICKY_EN
        check("sticky_set", 32'(sticky[0]), 32'h1);
        @(posedge clk);
        #1;
        sticky_clr[0] = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr[0] = 1'b0;
        check("sticky_clear_alone", 32'(sticky[0]), 32'h0);
        offer(0, 33'h0_0000_0001, 1'b0, 1'b1, 1'b1);
        bubble();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        sticky_clr[0] = 1'b1;
        check("sticky_coincident_out_valid", 32'(out_valid[0]), 32'h1);
        @(posedge clk);
        #1;
        sticky_clr[0] = 1'b0;
        check("sticky_survives_clear", 32'(sticky[0]), 32'h1);
        drain();
`endif

        // WIDTH=1: single stage, one-cycle latency
        offer(1, 33'h1, 1'b0, 1'b1, 1'b1);
        offer(1, 33'h0, 1'b0, 1'b0, 1'b1);
        offer(1, 33'h0, 1'b1, 1'b1, 1'b1);
        offer(1, 33'h1, 1'b1, 1'b0, 1'b1);
        drain();

        // WIDTH=33: top bit alone must reach the result through the padded tree
        offer(2, 33'h1_0000_0000, 1'b0, 1'b1, 1'b1);
        offer(2, 33'h0_0000_0000, 1'b0, 1'b0, 1'b1);
        offer(2, 33'h1_0000_0000, 1'b1, 1'b0, 1'b1);
        offer(2, 33'h0_0000_0000, 1'b1, 1'b1, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
